// File: rtl/spi_adc_rd_pkg.sv
// Shared SPI definitions: FSM state encoding and mode-0 bus constants.
package spi_adc_rd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic CPOL = 1'b0;  // SCLK idle level
  localparam logic CPHA = 1'b0;  // sample on leading edge

endpackage

// File: rtl/spi_adc_rd_sclk_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV enabled cycles while running.
// en_i low freezes the count; rise_o flags whether the coming SCLK edge is a rising one.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic en_i,
  input  logic sclk_i,
  output logic tick_o,
  output logic rise_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick_o = run_i && en_i && (div_cnt == DIV_MAX);
  assign rise_o = ~sclk_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt <= '0;
    end else if (!run_i) begin
      div_cnt <= '0;
    end else if (en_i) begin
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_adc_rd.sv
// Mode-0 SPI master: one full-duplex DATA_W-bit transfer per start pulse, z_o after
// (2*DATA_W+2)*CLK_DIV+1 cycles; en_i low pauses SETUP/SHIFT/HOLD in place.
module spi_adc_rd
  import spi_adc_rd_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] cmd_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              cs_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              z_o
);

  localparam int HW = $clog2(2 * DATA_W + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [HW-1:0]     half_cnt;
  logic              run;
  logic              tick;
  logic              rise;

  assign run = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (run),
    .en_i   (en_i),
    .sclk_i (sclk_o),
    .tick_o (tick),
    .rise_o (rise)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      half_cnt <= '0;
      sclk_o   <= CPOL;
      cs_o     <= 1'b1;
      mosi_o   <= 1'b0;
      data_o   <= '0;
      busy_o   <= 1'b0;
      z_o      <= 1'b0;
    end else begin
      z_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            tx_sr    <= cmd_i;
            mosi_o   <= cmd_i[DATA_W-1];
            cs_o     <= 1'b0;
            busy_o   <= 1'b1;
            half_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk_o <= ~sclk_o;
            if (rise) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
            end else begin
              tx_sr  <= tx_sr << 1;
              mosi_o <= tx_sr[DATA_W-2];
            end
            // The final tick is the last falling edge, leaving SCLK low.
            if (half_cnt == HALF_LAST) begin
              half_cnt <= '0;
              state    <= HOLD;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_o   <= 1'b1;
            data_o <= rx_sr;
            z_o    <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_rd.sv
// Directed bench for spi_adc_rd: loopback, ADC model, pause, ignored starts, back-to-back, reset.
module tb_spi_adc_rd;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        en_i = 1'b1;
  logic [15:0] cmd_i = '0;
  logic        miso_i;
  logic        sclk_o, cs_o, mosi_o, busy_o, z_o;
  logic [15:0] data_o;

  logic        loop_mode = 1'b1;
  logic [15:0] adc_sr = '0;
  logic [15:0] mosi_cap = '0;
  int          rise_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  spi_adc_rd #(.DATA_W(16), .CLK_DIV(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .en_i    (en_i),
    .cmd_i   (cmd_i),
    .miso_i  (miso_i),
    .sclk_o  (sclk_o),
    .cs_o    (cs_o),
    .mosi_o  (mosi_o),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .z_o     (z_o)
  );

  always #5 clk_i = ~clk_i;

  assign miso_i = loop_mode ? mosi_o : adc_sr[15];

  // ADC presents its next bit after every SCLK fall; MOSI is captured at every rise.
  always @(negedge sclk_o) adc_sr = {adc_sr[14:0], 1'b0};
  always @(posedge sclk_o) begin
    mosi_cap = {mosi_cap[14:0], mosi_o};
    rise_cnt = rise_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drives start_i for exactly one cycle; returns 1 cycle after the start cycle.
  task automatic start_xfer(input logic [15:0] cmd);
    cmd_i   = cmd;
    start_i = 1'b1;
    rise_cnt = 0;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_z(input int n0, output int n);
    n = n0;
    while (z_o !== 1'b1 && n < n0 + 400) begin
      step(1);
      n++;
    end
  endtask

  int lat;
  int zc;
  int first_z;
  logic sclk_s, mosi_s;

  initial begin
    // Reset values
    step(3);
    chk("rst_sclk", 32'(sclk_o), 32'h0);
    chk("rst_cs",   32'(cs_o),   32'h1);
    chk("rst_mosi", 32'(mosi_o), 32'h0);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_z",    32'(z_o),    32'h0);
    rst_i = 1'b1;
    step(2);

    // Loopback A5C3
    loop_mode = 1'b1;
    start_xfer(16'hA5C3);
    wait_z(1, lat);
    chk("lb_latency", 32'(lat), 32'd137);
    chk("lb_data",    32'(data_o), 32'h0000A5C3);
    chk("lb_rises",   32'(rise_cnt), 32'd16);
    chk("lb_busy_done", 32'(busy_o), 32'h1);
    chk("lb_cs_done",   32'(cs_o), 32'h1);
    step(1);
    chk("lb_z_pulse", 32'(z_o), 32'h0);
    chk("lb_busy_end", 32'(busy_o), 32'h0);
    step(2);

    // ADC model returning 1234 while sending 5A0F
    loop_mode = 1'b0;
    adc_sr = 16'h1234;
    start_xfer(16'h5A0F);
    wait_z(1, lat);
    chk("adc_latency", 32'(lat), 32'd137);
    chk("adc_data",    32'(data_o), 32'h00001234);
    chk("adc_mosi",    32'(mosi_cap), 32'h00005A0F);
    step(3);

    // Pause for 10 cycles mid-SHIFT
    loop_mode = 1'b1;
    start_xfer(16'h3C96);
    step(39);
    sclk_s = sclk_o;
    mosi_s = mosi_o;
    en_i = 1'b0;
    step(10);
    chk("pause_sclk", 32'(sclk_o), 32'(sclk_s));
    chk("pause_mosi", 32'(mosi_o), 32'(mosi_s));
    chk("pause_busy", 32'(busy_o), 32'h1);
    en_i = 1'b1;
    wait_z(50, lat);
    chk("pause_latency", 32'(lat), 32'd147);
    chk("pause_data",    32'(data_o), 32'h00003C96);
    step(3);

    // Re-pulsed starts at cycles 5 and 137 are ignored
    start_xfer(16'h0FF1);
    zc = 0;
    first_z = 0;
    for (int n = 2; n <= 141; n++) begin
      step(1);
      if (z_o === 1'b1) begin
        zc++;
        if (first_z == 0) first_z = n;
      end
      if (n == 5)   begin start_i = 1'b1; cmd_i = 16'hFFFF; end
      if (n == 6)   start_i = 1'b0;
      if (n == 137) start_i = 1'b1;
      if (n == 138) start_i = 1'b0;
    end
    chk("ign_zcount",  32'(zc), 32'd1);
    chk("ign_latency", 32'(first_z), 32'd137);
    chk("ign_data",    32'(data_o), 32'h00000FF1);
    chk("ign_busy",    32'(busy_o), 32'h0);
    step(2);

    // Back-to-back transfers
    start_xfer(16'h6E2B);
    wait_z(1, lat);
    chk("b2b_data1", 32'(data_o), 32'h00006E2B);
    step(1);
    chk("b2b_cs_gap", 32'(cs_o), 32'h1);
    start_xfer(16'hD13C);
    wait_z(1, lat);
    chk("b2b_latency2", 32'(lat), 32'd137);
    chk("b2b_data2",    32'(data_o), 32'h0000D13C);
    step(3);

    // Reset mid-SHIFT
    start_xfer(16'hBEEF);
    step(60);
    chk("mid_cs_low", 32'(cs_o), 32'h0);
    rst_i = 1'b0;
    #1;
    chk("arst_cs",   32'(cs_o),   32'h1);
    chk("arst_sclk", 32'(sclk_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    step(3);
    rst_i = 1'b1;
    zc = 0;
    for (int n = 0; n < 200; n++) begin
      step(1);
      if (z_o === 1'b1) zc++;
    end
    chk("arst_no_z", 32'(zc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
